// File: rtl/pll_phase_stepper.sv
// Dynamic phase-shift controller for the GTP_PLL_E1 wrapper.
//
// Accepts one phase-shift request at a time (valid/ready). It drives phase_sel
// and phase_dir from the latched request, then issues req_steps active-low
// pulses on phase_step_n. Each pulse is STEP_LOW_CYCLES long and is followed by
// a STEP_GAP_CYCLES high gap. After the last gap it waits for the synchronised
// PLL lock. It reports completion with a one-cycle done pulse. err is asserted
// with done when the lock wait times out.
//
// Ports:
//   clk, rst      reference-domain clock; synchronous active-high reset
//   req_valid     request valid
//   req_ready     request can be accepted (combinational: idle and not in reset)
//   req_sel       target PLL output index
//   req_dir       1 = advance, 0 = retard
//   req_steps     number of step pulses (0 allowed)
//   phase_sel     to PLL phase_sel (held from accept until the next accept)
//   phase_dir     to PLL phase_dir (held from accept until the next accept)
//   phase_step_n  to PLL phase_step_n, active-low step pulse
//   pll_lock      PLL lock, asynchronous to clk
//   busy          high whenever the controller is not idle
//   done          one-cycle completion pulse
//   err           one-cycle lock-timeout pulse, coincident with done
module pll_phase_stepper #(
  parameter int unsigned STEP_LOW_CYCLES = 4,
  parameter int unsigned STEP_GAP_CYCLES = 8,
  parameter int unsigned LOCK_TIMEOUT    = 1024,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_sel,
  input  logic             req_dir,
  input  logic [CNT_W-1:0] req_steps,
  output logic [2:0]       phase_sel,
  output logic             phase_dir,
  output logic             phase_step_n,
  input  logic             pll_lock,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned PhaseMax =
      (STEP_LOW_CYCLES > STEP_GAP_CYCLES) ? STEP_LOW_CYCLES : STEP_GAP_CYCLES;
  localparam int unsigned PhaseW   = $clog2(PhaseMax + 1);
  localparam int unsigned TmoW     = $clog2(LOCK_TIMEOUT + 1);

  // Terminal counts: each counter starts at 0 on state entry, so the last
  // cycle in a state is reached at (length - 1).
  localparam logic [PhaseW-1:0] LowLast = PhaseW'(STEP_LOW_CYCLES - 1);
  localparam logic [PhaseW-1:0] GapLast = PhaseW'(STEP_GAP_CYCLES - 1);
  localparam logic [TmoW-1:0]   TmoLast = TmoW'(LOCK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StPulse,
    StGap,
    StWaitLock,
    StDone
  } state_e;

  state_e            state_q;
  logic [PhaseW-1:0] phase_cnt_q;
  logic [CNT_W-1:0]  steps_q;
  logic [TmoW-1:0]   tmo_q;
  logic [2:0]        sel_q;
  logic              dir_q;
  logic              step_n_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              lock_meta_q;
  logic              lock_s_q;

  // Two-flop synchroniser for the asynchronous PLL lock.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= pll_lock;
      lock_s_q    <= lock_meta_q;
    end
  end

  assign req_ready = (state_q == StIdle) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      phase_cnt_q <= '0;
      steps_q     <= '0;
      tmo_q       <= '0;
      sel_q       <= 3'd0;
      dir_q       <= 1'b0;
      step_n_q    <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // done/err are single-cycle pulses raised on the transition into StDone.
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid && req_ready) begin
            sel_q       <= req_sel;
            dir_q       <= req_dir;
            steps_q     <= req_steps;
            phase_cnt_q <= '0;
            tmo_q       <= '0;
            busy_q      <= 1'b1;
            if (req_steps == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StSetup;
            end
          end
        end

        // One cycle for phase_sel/phase_dir to settle before the first pulse.
        StSetup: begin
          state_q     <= StPulse;
          step_n_q    <= 1'b0;
          phase_cnt_q <= '0;
        end

        StPulse: begin
          if (phase_cnt_q == LowLast) begin
            state_q     <= StGap;
            step_n_q    <= 1'b1;
            phase_cnt_q <= '0;
            steps_q     <= steps_q - 1'b1;
          end else begin
            phase_cnt_q <= phase_cnt_q + 1'b1;
          end
        end

        StGap: begin
          if (phase_cnt_q == GapLast) begin
            phase_cnt_q <= '0;
            if (steps_q != '0) begin
              state_q  <= StPulse;
              step_n_q <= 1'b0;
            end else begin
              state_q <= StWaitLock;
              tmo_q   <= '0;
            end
          end else begin
            phase_cnt_q <= phase_cnt_q + 1'b1;
          end
        end

        // Lock takes priority over a timeout landing in the same cycle.
        StWaitLock: begin
          if (lock_s_q) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else if (tmo_q == TmoLast) begin
            state_q <= StDone;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end

        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q  <= StIdle;
          busy_q   <= 1'b0;
          step_n_q <= 1'b1;
        end
      endcase
    end
  end

  assign phase_sel    = sel_q;
  assign phase_dir    = dir_q;
  assign phase_step_n = step_n_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_pll_phase_stepper.sv
// Scoreboard bench for pll_phase_stepper. The driver computes the completion
// cycle, the err flag and every pulse start time for each request from the
// timing rules. These values go into queues. A monitor sampling 1ns after
// each rising edge pops and compares whenever the DUT shows a pulse or done.
module tb_pll_phase_stepper;

  localparam int LowCycles   = 4;
  localparam int GapCycles   = 8;
  localparam int LockTimeout = 16;
  localparam int CntW        = 8;
  localparam int Period      = LowCycles + GapCycles;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_sel;
  logic            req_dir;
  logic [CntW-1:0] req_steps;
  logic [2:0]      phase_sel;
  logic            phase_dir;
  logic            phase_step_n;
  logic            pll_lock;
  logic            busy;
  logic            done;
  logic            err;

  pll_phase_stepper #(
    .STEP_LOW_CYCLES(LowCycles),
    .STEP_GAP_CYCLES(GapCycles),
    .LOCK_TIMEOUT   (LockTimeout),
    .CNT_W          (CntW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_sel     (req_sel),
    .req_dir     (req_dir),
    .req_steps   (req_steps),
    .phase_sel   (phase_sel),
    .phase_dir   (phase_dir),
    .phase_step_n(phase_step_n),
    .pll_lock    (pll_lock),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Cycle k is the interval between rising edge k and rising edge k+1.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    int   done_cyc;
    logic err;
    int   sel;
    int   dir;
  } exp_t;

  exp_t exp_q[$];
  int   pulse_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: pulse start/width and completion scoreboard.
  initial begin
    logic prev_n;
    int   low_start;
    exp_t e;
    prev_n    = 1'b1;
    low_start = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        prev_n = 1'b1;
      end else begin
        if (prev_n && !phase_step_n) begin
          low_start = cyc;
          if (pulse_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_pulse: phase_step_n fell at cycle %0d, none expected", cyc);
          end else begin
            check("pulse_start", cyc, pulse_q.pop_front());
          end
        end
        if (!prev_n && phase_step_n) check("pulse_low_len", cyc - low_start, LowCycles);
        prev_n = phase_step_n;
        if (done) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_done: done high at cycle %0d, none expected", cyc);
          end else begin
            e = exp_q.pop_front();
            check("done_cycle", cyc, e.done_cyc);
            check("done_err", int'(err), int'(e.err));
            check("done_sel", int'(phase_sel), e.sel);
            check("done_dir", int'(phase_dir), e.dir);
          end
        end
        if (err) check("err_needs_done", int'(done), 1);
      end
    end
  end

  // Issue one request starting at a negedge, then drive pll_lock and run until
  // the cycle after the expected done. The lock rises at (WAIT_LOCK entry + d).
  // It is random noise earlier than two cycles before entry.
  task automatic issue(input int sel, input int dir, input int steps, input int d,
                       input bit hold, input bit b2b, inout int last_e);
    int a, w, c, e;
    logic e_err;
    int guard;
    exp_t ex;
    req_sel   = 3'(sel);
    req_dir   = 1'(dir);
    req_steps = 8'(steps);
    req_valid = 1'b1;
    guard     = 0;
    while (!req_ready && guard < 10000) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      n_checks++;
      n_err++;
      $display("FAIL accept_timeout: req_ready never rose, got 0 expected 1");
      req_valid = 1'b0;
      return;
    end
    a = cyc;
    if (b2b) check("b2b_accept_cycle", a, last_e + 1);
    w = a + 2 + Period * steps;
    if (steps == 0) begin
      e     = a + 1;
      e_err = 1'b0;
    end else begin
      c = (d + 2 > 0) ? w + d + 2 : w;
      if (c <= w + LockTimeout - 1) begin
        e     = c + 1;
        e_err = 1'b0;
      end else begin
        e     = w + LockTimeout;
        e_err = 1'b1;
      end
    end
    ex.done_cyc = e;
    ex.err      = e_err;
    ex.sel      = sel;
    ex.dir      = dir;
    exp_q.push_back(ex);
    for (int k = 0; k < steps; k++) pulse_q.push_back(a + 2 + Period * k);
    while (cyc < e + 1) begin
      @(negedge clk);
      if (cyc == a + 1) begin
        check("setup_sel", int'(phase_sel), sel);
        check("setup_dir", int'(phase_dir), dir);
        check("setup_busy", int'(busy), 1);
        check("setup_step_n", int'(phase_step_n), 1);
      end
      if (hold) begin
        req_sel   = 3'($urandom);
        req_dir   = 1'($urandom);
        req_steps = 8'($urandom);
      end else begin
        req_valid = 1'b0;
      end
      if (steps == 0 || cyc + 2 < w) pll_lock = 1'($urandom_range(0, 1));
      else pll_lock = (cyc >= w + d);
    end
    check("ready_after_done", int'(req_ready), 1);
    check("idle_busy", int'(busy), 0);
    last_e = e;
  endtask

  initial begin
    #1_000_000;
    n_checks++;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    int last_e;
    int a;
    last_e    = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_sel   = 3'd0;
    req_dir   = 1'b0;
    req_steps = '0;
    pll_lock  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", int'(req_ready), 0);
    check("rst_step_n", int'(phase_step_n), 1);
    check("rst_sel", int'(phase_sel), 0);
    check("rst_dir", int'(phase_dir), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    rst = 1'b0;
    @(negedge clk);

    issue(2, 1, 3, -2, 1'b0, 1'b0, last_e);    // nominal three-step shift
    issue(5, 0, 0, -2, 1'b0, 1'b0, last_e);    // zero steps
    issue(1, 1, 1, 100, 1'b0, 1'b0, last_e);   // lock never comes: timeout
    issue(3, 0, 2, 5, 1'b0, 1'b0, last_e);     // lock rises 5 cycles into wait
    issue(4, 1, 1, 13, 1'b0, 1'b0, last_e);    // lock seen on last wait cycle
    issue(0, 0, 1, 14, 1'b0, 1'b0, last_e);    // lock one cycle too late

    // Reset during the second pulse of a four-step request.
    req_sel   = 3'd4;
    req_dir   = 1'b1;
    req_steps = 8'd4;
    req_valid = 1'b1;
    a = cyc;
    check("rst_test_ready", int'(req_ready), 1);
    pulse_q.push_back(a + 2);
    pulse_q.push_back(a + 2 + Period);
    @(negedge clk);
    req_valid = 1'b0;
    while (cyc < a + 15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_step_n", int'(phase_step_n), 1);
    check("midrst_done", int'(done), 0);
    check("midrst_err", int'(err), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_ready", int'(req_ready), 0);
    check("midrst_sel", int'(phase_sel), 0);
    rst = 1'b0;
    @(negedge clk);
    check("postrst_ready", int'(req_ready), 1);
    issue(6, 1, 2, 0, 1'b0, 1'b0, last_e);

    // req_valid held high with fields churning while busy.
    issue(1, 0, 2, -2, 1'b1, 1'b0, last_e);
    issue(2, 1, 1, 3, 1'b1, 1'b1, last_e);
    issue(7, 0, 0, -2, 1'b1, 1'b1, last_e);
    issue(3, 1, 1, -2, 1'b1, 1'b1, last_e);
    req_valid = 1'b0;

    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
            int'($urandom_range(0, 5)), int'($urandom_range(0, 22)) - 2,
            1'b0, 1'b0, last_e);
    end

    issue(0, 1, 255, -2, 1'b0, 1'b0, last_e);  // maximum step count

    repeat (5) @(negedge clk);
    check("exp_queue_empty", exp_q.size(), 0);
    check("pulse_queue_empty", pulse_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
